control_unit: RTL and testbench

Control unit for the single-cycle ARM-subset processor. It decodes the `cond`/`op`/`funct`/`rd` fields driven by the datapath and produces every datapath control strobe. It holds the NZCV status register, evaluates the condition field against it, and owns a sticky fault state machine that stops all architectural commits after an unsupported instruction. It sits beside the datapath in the processor top level, one instance per core.

---
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Decode, NZCV status register, condition check and sticky fault FSM for the single-cycle ARM subset.
// Optional performance counters are built only when CONTROL_PERF_COUNTERS_EN is defined.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rd,
    input  logic [3:0]  alu_flags,
    output logic        pc_src,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags,
    output logic        fault,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;

    state_t state, state_next;
    logic   supported;
    logic   writes_rd;
    logic   is_str;
    logic   is_branch;
    logic   arith_flags;
    logic   cond_ex;
    logic   commit_ok;
    logic   flag_update;
    logic   n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Mux selects are decoded unconditionally; only the commit strobes are gated later.
    always_comb begin
        supported   = 1'b0;
        writes_rd   = 1'b0;
        is_str      = 1'b0;
        is_branch   = 1'b0;
        arith_flags = 1'b0;
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_src     = 2'b00;
        case (op)
            2'b00: begin
                alu_src   = funct[5];
                supported = 1'b1;
                writes_rd = 1'b1;
                case (funct[4:1])
                    4'b0100: begin alu_control = ALU_ADD; arith_flags = 1'b1; end
                    4'b0010: begin alu_control = ALU_SUB; arith_flags = 1'b1; end
                    4'b0000: alu_control = ALU_AND;
                    4'b1100: alu_control = ALU_ORR;
                    4'b0001: alu_control = ALU_EOR;
                    4'b1010: begin
                        alu_control = ALU_SUB;
                        arith_flags = 1'b1;
                        writes_rd   = 1'b0;
                        supported   = funct[0];
                    end
                    default: begin
                        supported = 1'b0;
                        writes_rd = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                alu_src    = 1'b1;
                mem_to_reg = funct[0];
                reg_src    = funct[0] ? 2'b00 : 2'b10;
                supported  = (funct[5:1] == 5'b01100);
                writes_rd  = funct[0];
                is_str     = !funct[0];
            end
            2'b10: begin
                alu_src   = 1'b1;
                reg_src   = 2'b01;
                supported = 1'b1;
                is_branch = 1'b1;
            end
            default: supported = 1'b0;
        endcase
    end

    assign commit_ok   = rst && (state == RUN) && supported && cond_ex;
    assign pc_src      = commit_ok && (is_branch || (writes_rd && rd == 4'd15));
    assign reg_write   = commit_ok && writes_rd && (rd != 4'd15);
    assign mem_write   = commit_ok && is_str;
    assign flag_update = commit_ok && (op == 2'b00) && funct[0];
    assign fault       = (state == FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= 4'b0000;
        end else if (flag_update) begin
            if (arith_flags)
                flags <= alu_flags;
            else
                flags <= {alu_flags[3:2], flags[1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == RUN && !supported)
            state_next = FAULT;
    end

`ifdef CONTROL_PERF_COUNTERS_EN
    logic [31:0] cycle_q;
    logic [31:0] retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= 32'd0;
            retired_q <= 32'd0;
        end else if (state == RUN) begin
            cycle_q <= cycle_q + 32'd1;
            if (supported && cond_ex)
                retired_q <= retired_q + 32'd1;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
`else
    assign cycle_count   = 32'd0;
    assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  alu_flags;
    logic        pc_src, mem_to_reg, mem_write, alu_src, reg_write, fault;
    logic [3:0]  alu_control, flags;
    logic [1:0]  reg_src;
    logic [31:0] cycle_count, retired_count;

    int tests_run = 0;
    int fail_count = 0;

    typedef struct {
        string       name;
        logic [79:0] exp;
        logic [79:0] mask;
    } exp_t;

    exp_t sb[$];

    localparam logic [79:0] MC  = {64'h0, 16'hFFFF};
    localparam logic [79:0] MNM = {64'h0, 16'hA09F};
    localparam logic [79:0] MA  = {80{1'b1}};

    control_unit dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .alu_control(alu_control), .alu_src(alu_src),
        .reg_write(reg_write), .reg_src(reg_src), .flags(flags), .fault(fault),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] e(input logic pc, input logic mtr, input logic mw,
                                      input logic [3:0] alu, input logic asrc, input logic rw,
                                      input logic [1:0] rs, input logic [3:0] fl, input logic ft);
        return {64'h0, pc, mtr, mw, alu, asrc, rw, rs, fl, ft};
    endfunction

    function automatic logic [79:0] observed();
        return {cycle_count, retired_count, pc_src, mem_to_reg, mem_write, alu_control,
                alu_src, reg_write, reg_src, flags, fault};
    endfunction

    task automatic checkOutput(input exp_t item);
        logic [79:0] got;
        got = observed();
        tests_run++;
        if ((got & item.mask) !== (item.exp & item.mask)) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h (mask %h)",
                     item.name, got & item.mask, item.exp & item.mask, item.mask);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0)
            checkOutput(sb.pop_front());
    end

    task automatic applyStimulus(input string name, input logic r, input logic [3:0] c,
                                 input logic [1:0] o, input logic [5:0] f, input logic [3:0] d,
                                 input logic [3:0] af, input logic [79:0] ex, input logic [79:0] m);
        exp_t item;
        @(posedge clk);
        #1;
        rst       = r;
        cond      = c;
        op        = o;
        funct     = f;
        rd        = d;
        alu_flags = af;
        item.name = name;
        item.exp  = ex;
        item.mask = m;
        sb.push_back(item);
    endtask

    logic [31:0] exp_cyc5, exp_ret5, exp_cycw, exp_retw;

    initial begin
`ifdef CONTROL_PERF_COUNTERS_EN
        exp_cyc5 = 32'd5; exp_ret5 = 32'd4; exp_cycw = 32'd0; exp_retw = 32'd5;
`else
        exp_cyc5 = 32'd0; exp_ret5 = 32'd0; exp_cycw = 32'd0; exp_retw = 32'd0;
`endif
        rst = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'b101001; rd = 4'd1; alu_flags = 4'b0110;

        applyStimulus("reset_gate", 0, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110,
                      e(0,0,0,4'b0000,1,0,2'b00,4'b0000,0), MA);
        applyStimulus("adds_imm", 1, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110,
                      e(0,0,0,4'b0000,1,1,2'b00,4'b0000,0), MC);
        applyStimulus("adds_reg_flags0110", 1, 4'hE, 2'b00, 6'b001001, 4'd2, 4'b0100,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0110,0), MC);
        applyStimulus("str_eq", 1, 4'h0, 2'b01, 6'b011000, 4'd3, 4'b0000,
                      e(0,0,1,4'b0000,1,0,2'b10,4'b0100,0), MC);
        applyStimulus("str_ne", 1, 4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000,
                      e(0,0,0,4'b0000,1,0,2'b10,4'b0100,0), MC);
        applyStimulus("branch", 1, 4'hE, 2'b10, 6'b101000, 4'd0, 4'b0000,
                      e(1,0,0,4'b0000,1,0,2'b01,4'b0100,0), MC);
        applyStimulus("ldr_pc", 1, 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000,
                      e(1,1,0,4'b0000,1,0,2'b00,4'b0100,0), MC);
        applyStimulus("adds_set0011", 1, 4'hE, 2'b00, 6'b001001, 4'd1, 4'b0011,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0100,0), MC);
        applyStimulus("ands", 1, 4'hE, 2'b00, 6'b000001, 4'd2, 4'b1011,
                      e(0,0,0,4'b0010,0,1,2'b00,4'b0011,0), MC);
        applyStimulus("subs_pc", 1, 4'hE, 2'b00, 6'b100101, 4'd15, 4'b0000,
                      e(1,0,0,4'b0001,1,0,2'b00,4'b1011,0), MC);
        applyStimulus("orr_gt", 1, 4'hC, 2'b00, 6'b011000, 4'd4, 4'b1111,
                      e(0,0,0,4'b0011,0,1,2'b00,4'b0000,0), MC);
        applyStimulus("eor_lt_fail", 1, 4'hB, 2'b00, 6'b000010, 4'd4, 4'b1111,
                      e(0,0,0,4'b0100,0,0,2'b00,4'b0000,0), MC);
        applyStimulus("cmp", 1, 4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000,
                      e(0,0,0,4'b0001,0,0,2'b00,4'b0000,0), MC);
        applyStimulus("orr_mi", 1, 4'h4, 2'b00, 6'b011000, 4'd5, 4'b0000,
                      e(0,0,0,4'b0011,0,1,2'b00,4'b1000,0), MC);
        applyStimulus("op11_fault_cycle", 1, 4'hE, 2'b11, 6'b000000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,0,2'b00,4'b1000,0), MNM);
        applyStimulus("adds_in_fault", 1, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110,
                      e(0,0,0,4'b0000,1,0,2'b00,4'b1000,1), MC);
        applyStimulus("flags_frozen", 1, 4'hE, 2'b00, 6'b001001, 4'd2, 4'b0001,
                      e(0,0,0,4'b0000,0,0,2'b00,4'b1000,1), MC);
        applyStimulus("reset_mid_fault", 0, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110,
                      e(0,0,0,4'b0000,1,0,2'b00,4'b0000,0), MC);
        applyStimulus("run_after_reset", 1, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110,
                      e(0,0,0,4'b0000,1,1,2'b00,4'b0000,0), MC);
        applyStimulus("cmp_nos_fault_cycle", 1, 4'hE, 2'b00, 6'b010100, 4'd0, 4'b0000,
                      e(0,0,0,4'b0001,0,0,2'b00,4'b0110,0), MC);
        applyStimulus("cmp_nos_faulted", 1, 4'hE, 2'b10, 6'b000000, 4'd0, 4'b0000,
                      e(0,0,0,4'b0000,1,0,2'b01,4'b0110,1), MC);

        applyStimulus("counters_reset", 0, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,0,2'b00,4'b0000,0), MA);
        applyStimulus("cnt_i1", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MC);
        applyStimulus("cnt_i2", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MC);
        applyStimulus("cnt_i3_nv", 1, 4'hF, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,0,2'b00,4'b0000,0), MC);
        applyStimulus("cnt_i4", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MC);
        applyStimulus("cnt_i5", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MC);
        applyStimulus("counters_5_4", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      {exp_cyc5, exp_ret5, 16'h0} | e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MA);
        @(negedge clk);
        #1;
`ifdef CONTROL_PERF_COUNTERS_EN
        dut.cycle_q = 32'hFFFF_FFFF;
`endif
        applyStimulus("cycle_wrap", 1, 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000,
                      {exp_cycw, exp_retw, 16'h0} | e(0,0,0,4'b0000,0,1,2'b00,4'b0000,0), MA);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
